chacha20_block_core: RTL and testbench
======================================

Name: chacha20_block_core

Overview:
Iterative ChaCha20 block function (RFC 7539 §2.3). It accepts a 16-word, 32-bit input state (constants, key, counter, nonce) and runs 20 rounds, one round per clock. It then adds the original input state word-wise mod 2^32 and presents the 16-word keystream block with a one-cycle done pulse. It sits below the stream-cipher/keystream controller, which assembles state_in and consumes state_out.

Parameters:
ROUNDS, 20, total number of rounds (even; column/diagonal rounds alternate).

Ports:
clk  input  1  clock; all state updates on rising edge
rst_n  input  1  asynchronous active-low reset
start  input  1  request; sampled on rising edge while idle
state_in  input  32 x [0:15]  input state (unpacked array), words 0..15 per RFC 7539
done  output  1  one-cycle pulse: state_out is valid
state_out  output  32 x [0:15]  keystream block = rounds(state_in) + state_in

Behaviour:
- Reset (rst_n low, asynchronous): FSM to IDLE, round counter 0, done 0, all state_out words 0, working and original-state registers 0.
- Quarter round QR(a,b,c,d), all arithmetic 32-bit wrap-around:
  - a+=b; d^=a; d<<<=16
  - c+=d; b^=c; b<<<=12
  - a+=b; d^=a; d<<<=8
  - c+=d; b^=c; b<<<=7
- Column round: QR(0,4,8,12), QR(1,5,9,13), QR(2,6,10,14), QR(3,7,11,15).
- Diagonal round: QR(0,5,10,15), QR(1,6,11,12), QR(2,7,8,13), QR(3,4,9,14).
- Each round is four parallel combinational QRs, registered once per cycle.
- FSM states:
  - IDLE: on rising edge with start=1, latch state_in into working regs x[] and original regs o[]; round counter 0; go to ROUND.
  - ROUND: each cycle, x <= column round(x) if counter even, else diagonal round(x); counter++. After the cycle applying round ROUNDS-1, go to FINAL.
  - FINAL: state_out[i] <= x[i] + o[i] for all i; done <= 1 for exactly this one registered cycle; return to IDLE.
- Latency: start sampled at edge N → done high during the cycle following edge N+ROUNDS+1 (21+1 edges for ROUNDS=20). Done is a single-cycle pulse.
- state_out holds its value after done until the next completion; it changes only in FINAL.
- start while busy (ROUND/FINAL) is ignored; no queueing.
- start held high continuously: a new block begins on the first IDLE edge after done.
- state_in is only sampled at accepted start; it may change freely afterwards.
- rst_n asserted mid-operation aborts immediately; no done pulse is produced; outputs are zeroed.

Decomposition:
- Package chacha20_pkg: word_t (logic [31:0]); state_t (word_t [0:15]); constants SIGMA0..3 = 61707865, 3320646e, 79622d32, 6b206574; default ROUNDS.
- Sub-module chacha20_qr: purely combinational quarter round, inputs a,b,c,d and outputs a',b',c',d'. Instantiated 4 times with round-dependent input muxing (column vs diagonal index sets).

Test Plan:
- QR unit check: a=11111111 b=01020304 c=9b8d6f43 d=01234567 → ea2a92f4 cb1cf8ce 4581472e 5881c4bb.
- RFC 7539 §2.3.2 block:
  - state_in = 61707865 3320646e 79622d32 6b206574 03020100 07060504 0b0a0908 0f0e0d0c 13121110 17161514 1b1a1918 1f1e1d1c 00000001 09000000 4a000000 00000000; pulse start.
  - Required: done pulses exactly once after 21 cycles, with state_out = e4e7f110 15593bd1 1fdd0f50 c47120a3 c7f4d1c7 0368c033 9aaa2204 4e6cd4c3 466482d2 09aa9f07 05d7c214 a2028bd9 d19c12b5 b94e16de e883d0cb 4e3c50a2.
- All-zero state_in, start → done pulse with all 16 state_out words 00000000.
- Busy handling: pulse start with §2.3.2 vector, then assert start again and change state_in mid-run → done pulses once with the §2.3.2 result; a second block starts only after return to IDLE.
- Async reset: drop rst_n at round 10 → done, state_out immediately 0. Release rst_n and restart → correct §2.3.2 result after full latency.
- Back-to-back: hold start high across two blocks (counter 1, then counter 2) → two done pulses 22 edges apart. state_out holds the first result between the pulses.

Source files
------------

// File: rtl/chacha20_pkg.sv
// Shared types, constants and helpers for the ChaCha20 block core.
// Word/state types, sigma constants, FSM encoding and index mapping.
package chacha20_pkg;

   typedef logic [31:0] word_t;
   typedef word_t [0:15] state_t;

   localparam word_t SIGMA0 = 32'h61707865;
   localparam word_t SIGMA1 = 32'h3320646e;
   localparam word_t SIGMA2 = 32'h79622d32;
   localparam word_t SIGMA3 = 32'h6b206574;

   localparam int DEFAULT_ROUNDS = 20;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_ROUND,
      ST_FINAL
   } fsm_t;

   function automatic word_t rotl(input word_t v, input int unsigned n);
      return (v << n) | (v >> (32 - n));
   endfunction

   // State word feeding row 'row' (a=0,b=1,c=2,d=3) of quarter round 'q'.
   // Diagonal rounds rotate each row left by its row number.
   function automatic logic [3:0] qidx(input logic [1:0] row, input logic [1:0] q,
                                       input logic diag);
      logic [1:0] col;
      col = q + (diag ? row : 2'd0);
      return {row, col};
   endfunction

endpackage

// File: rtl/chacha20_block_core_if.sv
// Request/result bundle between the keystream controller and the block core.
interface chacha20_block_core_if;
   import chacha20_pkg::*;

   logic  start;
   word_t state_in  [0:15];
   logic  done;
   word_t state_out [0:15];

   modport master (output start, state_in, input done, state_out);
   modport slave  (input start, state_in, output done, state_out);

endinterface

// File: rtl/chacha20_qr.sv
// ChaCha20 quarter round, purely combinational, 32-bit wrap-around arithmetic.
module chacha20_qr
   import chacha20_pkg::*;
(
   input  word_t a_i,
   input  word_t b_i,
   input  word_t c_i,
   input  word_t d_i,
   output word_t a_o,
   output word_t b_o,
   output word_t c_o,
   output word_t d_o
);

   word_t a1, b1, c1, d1;
   word_t a2, b2, c2, d2;

   assign a1 = a_i + b_i;
   assign d1 = rotl(d_i ^ a1, 16);
   assign c1 = c_i + d1;
   assign b1 = rotl(b_i ^ c1, 12);
   assign a2 = a1 + b1;
   assign d2 = rotl(d1 ^ a2, 8);
   assign c2 = c1 + d2;
   assign b2 = rotl(b1 ^ c2, 7);

   assign a_o = a2;
   assign b_o = b2;
   assign c_o = c2;
   assign d_o = d2;

endmodule

// File: rtl/chacha20_block_core.sv
// Iterative ChaCha20 block function: one double-half round per clock, then
// feed-forward add of the original state and a one-cycle done pulse.
//
//   state    | meaning
//   ---------+-----------------------------------------------------------
//   ST_IDLE  | waiting for start; latches state_in into x and o on start
//   ST_ROUND | applies column (even count) or diagonal (odd count) round
//   ST_FINAL | registers x + o into state_out, pulses done
module chacha20_block_core
   import chacha20_pkg::*;
#(
   parameter int ROUNDS = DEFAULT_ROUNDS
)(
   input  logic                 clk,
   input  logic                 rst_n,
   chacha20_block_core_if.slave bus
);

   localparam int CNT_W = $clog2(ROUNDS + 1);
   localparam logic [CNT_W-1:0] LAST_RND = CNT_W'(ROUNDS - 1);

   fsm_t             state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   state_t           x_q, x_d;
   state_t           o_q, o_d;
   state_t           out_q, out_d;
   logic             done_q, done_d;

   logic   diag;
   state_t x_rnd;
   word_t  qa_in  [4], qb_in  [4], qc_in  [4], qd_in  [4];
   word_t  qa_out [4], qb_out [4], qc_out [4], qd_out [4];

   assign diag = cnt_q[0];

   always_comb begin
      for (int q = 0; q < 4; q++) begin
         qa_in[q] = x_q[qidx(2'd0, 2'(q), diag)];
         qb_in[q] = x_q[qidx(2'd1, 2'(q), diag)];
         qc_in[q] = x_q[qidx(2'd2, 2'(q), diag)];
         qd_in[q] = x_q[qidx(2'd3, 2'(q), diag)];
      end
   end

   for (genvar g = 0; g < 4; g++) begin : g_qr
      chacha20_qr u_qr (
         .a_i (qa_in[g]),
         .b_i (qb_in[g]),
         .c_i (qc_in[g]),
         .d_i (qd_in[g]),
         .a_o (qa_out[g]),
         .b_o (qb_out[g]),
         .c_o (qc_out[g]),
         .d_o (qd_out[g])
      );
   end

   // Results go back to the same words they were taken from.
   always_comb begin
      x_rnd = x_q;
      for (int q = 0; q < 4; q++) begin
         x_rnd[qidx(2'd0, 2'(q), diag)] = qa_out[q];
         x_rnd[qidx(2'd1, 2'(q), diag)] = qb_out[q];
         x_rnd[qidx(2'd2, 2'(q), diag)] = qc_out[q];
         x_rnd[qidx(2'd3, 2'(q), diag)] = qd_out[q];
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      x_d     = x_q;
      o_d     = o_q;
      out_d   = out_q;
      done_d  = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (bus.start) begin
               for (int i = 0; i < 16; i++) begin
                  x_d[i] = bus.state_in[i];
                  o_d[i] = bus.state_in[i];
               end
               cnt_d   = '0;
               state_d = ST_ROUND;
            end
         end
         ST_ROUND: begin
            x_d   = x_rnd;
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == LAST_RND) begin
               state_d = ST_FINAL;
            end
         end
         ST_FINAL: begin
            for (int i = 0; i < 16; i++) begin
               out_d[i] = x_q[i] + o_q[i];
            end
            done_d  = 1'b1;
            state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
         x_q     <= '0;
         o_q     <= '0;
         out_q   <= '0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         x_q     <= x_d;
         o_q     <= o_d;
         out_q   <= out_d;
         done_q  <= done_d;
      end
   end

   assign bus.done = done_q;

   for (genvar g = 0; g < 16; g++) begin : g_out
      assign bus.state_out[g] = out_q[g];
   end

endmodule

// File: tb/tb_chacha20_block_core.sv
// Directed bench for chacha20_block_core: RFC 7539 vectors, busy, reset, back-to-back.
module tb_chacha20_block_core;
   import chacha20_pkg::*;

   logic clk;
   logic rst_n;
   int   vectors;
   int   miscompares;

   chacha20_block_core_if bus ();

   chacha20_block_core #(.ROUNDS(20)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   word_t qa, qb, qc, qd, ra, rb, rc, rd;

   chacha20_qr u_qr (
      .a_i (qa), .b_i (qb), .c_i (qc), .d_i (qd),
      .a_o (ra), .b_o (rb), .c_o (rc), .d_o (rd)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   word_t v_rfc [0:15] = '{
      32'h61707865, 32'h3320646e, 32'h79622d32, 32'h6b206574,
      32'h03020100, 32'h07060504, 32'h0b0a0908, 32'h0f0e0d0c,
      32'h13121110, 32'h17161514, 32'h1b1a1918, 32'h1f1e1d1c,
      32'h00000001, 32'h09000000, 32'h4a000000, 32'h00000000};
   word_t v_zero [0:15] = '{default: 32'h0};
   word_t v_c2 [0:15];

   localparam logic [511:0] RFC_EXP = {
      32'he4e7f110, 32'h15593bd1, 32'h1fdd0f50, 32'hc47120a3,
      32'hc7f4d1c7, 32'h0368c033, 32'h9aaa2204, 32'h4e6cd4c3,
      32'h466482d2, 32'h09aa9f07, 32'h05d7c214, 32'ha2028bd9,
      32'hd19c12b5, 32'hb94e16de, 32'he883d0cb, 32'h4e3c50a2};

   function automatic logic [511:0] flat(input word_t a [0:15]);
      logic [511:0] r;
      for (int i = 0; i < 16; i++) r[511-32*i -: 32] = a[i];
      return r;
   endfunction

   function automatic word_t rl(input word_t v, input int n);
      return (v << n) | (v >> (32 - n));
   endfunction

   // Straight-line RFC reference: ten double rounds, QRs applied in order.
   function automatic logic [511:0] ref_block(input word_t s [0:15]);
      word_t x [0:15];
      int ia [0:7] = '{0, 1, 2, 3, 0, 1, 2, 3};
      int ib [0:7] = '{4, 5, 6, 7, 5, 6, 7, 4};
      int ic [0:7] = '{8, 9, 10, 11, 10, 11, 8, 9};
      int id [0:7] = '{12, 13, 14, 15, 15, 12, 13, 14};
      word_t y [0:15];
      x = s;
      for (int dr = 0; dr < 10; dr++) begin
         for (int q = 0; q < 8; q++) begin
            x[ia[q]] = x[ia[q]] + x[ib[q]]; x[id[q]] = rl(x[id[q]] ^ x[ia[q]], 16);
            x[ic[q]] = x[ic[q]] + x[id[q]]; x[ib[q]] = rl(x[ib[q]] ^ x[ic[q]], 12);
            x[ia[q]] = x[ia[q]] + x[ib[q]]; x[id[q]] = rl(x[id[q]] ^ x[ia[q]], 8);
            x[ic[q]] = x[ic[q]] + x[id[q]]; x[ib[q]] = rl(x[ib[q]] ^ x[ic[q]], 7);
         end
      end
      for (int i = 0; i < 16; i++) y[i] = x[i] + s[i];
      return flat(y);
   endfunction

   task automatic check(input string tag, input logic [511:0] obs, input logic [511:0] exp);
      vectors++;
      assert (obs === exp)
      else begin
         miscompares++;
         $error("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic start_block(input word_t v [0:15]);
      bus.state_in = v;
      bus.start = 1'b1;
      @(posedge clk);
      #1;
      bus.start = 1'b0;
   endtask

   task automatic wait_done(input int window, output int lat, output int pulses);
      lat = -1;
      pulses = 0;
      for (int k = 1; k <= window; k++) begin
         @(posedge clk);
         #1;
         if (bus.done) begin
            pulses++;
            if (lat < 0) lat = k;
         end
      end
   endtask

   int lat, pul, l1, l2;
   logic [511:0] out2;

   initial begin
      vectors = 0;
      miscompares = 0;
      rst_n = 1'b0;
      bus.start = 1'b0;
      bus.state_in = v_zero;
      v_c2 = v_rfc;
      v_c2[12] = 32'h00000002;
      qa = 32'h11111111; qb = 32'h01020304; qc = 32'h9b8d6f43; qd = 32'h01234567;
      repeat (3) @(posedge clk);
      #1;
      check("reset_done", 512'(bus.done), 512'd0);
      check("reset_out", flat(bus.state_out), 512'd0);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      check("qr_unit", 512'({ra, rb, rc, rd}),
            512'(128'hea2a92f4_cb1cf8ce_4581472e_5881c4bb));

      start_block(v_rfc);
      wait_done(40, lat, pul);
      check("rfc_latency", 512'(lat), 512'(21));
      check("rfc_pulses", 512'(pul), 512'(1));
      check("rfc_out", flat(bus.state_out), RFC_EXP);

      start_block(v_zero);
      wait_done(40, lat, pul);
      check("zero_latency", 512'(lat), 512'(21));
      check("zero_pulses", 512'(pul), 512'(1));
      check("zero_out", flat(bus.state_out), 512'd0);

      // Start re-asserted with new data while busy must be ignored.
      start_block(v_rfc);
      lat = -1;
      pul = 0;
      for (int k = 1; k <= 40; k++) begin
         @(posedge clk);
         #1;
         if (bus.done) begin
            pul++;
            if (lat < 0) lat = k;
         end
         if (k == 5) begin
            bus.start = 1'b1;
            bus.state_in = v_zero;
         end
         if (k == 15) bus.start = 1'b0;
      end
      check("busy_latency", 512'(lat), 512'(21));
      check("busy_pulses", 512'(pul), 512'(1));
      check("busy_out", flat(bus.state_out), RFC_EXP);

      start_block(v_rfc);
      repeat (10) @(posedge clk);
      #1;
      rst_n = 1'b0;
      #1;
      check("areset_done", 512'(bus.done), 512'd0);
      check("areset_out", flat(bus.state_out), 512'd0);
      repeat (3) @(posedge clk);
      #3;
      rst_n = 1'b1;
      wait_done(30, lat, pul);
      check("areset_no_pulse", 512'(pul), 512'd0);
      start_block(v_rfc);
      wait_done(40, lat, pul);
      check("restart_latency", 512'(lat), 512'(21));
      check("restart_out", flat(bus.state_out), RFC_EXP);

      // Start held high: second block accepted on the IDLE edge after done.
      bus.state_in = v_rfc;
      bus.start = 1'b1;
      @(posedge clk);
      #1;
      bus.state_in = v_c2;
      l1 = -1;
      l2 = -1;
      pul = 0;
      out2 = '0;
      for (int k = 1; k <= 50; k++) begin
         @(posedge clk);
         #1;
         if (bus.done) begin
            pul++;
            if (l1 < 0) begin
               l1 = k;
               check("b2b_out1", flat(bus.state_out), RFC_EXP);
            end else if (l2 < 0) begin
               l2 = k;
               out2 = flat(bus.state_out);
            end
         end
         if (k == 22) bus.start = 1'b0;
         if (k == 30) check("b2b_hold", flat(bus.state_out), RFC_EXP);
      end
      check("b2b_first_latency", 512'(l1), 512'(21));
      check("b2b_spacing", 512'(l2 - l1), 512'(22));
      check("b2b_pulses", 512'(pul), 512'(2));
      check("b2b_out2", out2, ref_block(v_c2));

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
